// File: rtl/hex_display_pkg.sv
// Shared types and the hex-to-7-segment table for the HEX bank driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high here; the driver inverts them for the pins.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT
    } state_t;

    function automatic logic [6:0] hex_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        // NOTE: a default before the case keeps every path assigned, so no latch can be inferred.
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational nibble to active-high 7-segment pattern, shared by all digits
// because the driver decodes one digit per cycle.
module seg7_hex_encode
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_encode(i_nibble);

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex driver for the static 7-segment banks: captures a value over valid/ready,
// decodes one digit per cycle into a shadow bank, commits atomically, then applies blink.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      load_blank_lz,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    input  logic [NUM_DIGITS-1:0]     load_blink,
    output logic [7*NUM_DIGITS-1:0]   seg_out,
    output logic [NUM_DIGITS-1:0]     dp_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_lz;
    logic [NUM_DIGITS-1:0][3:0]      r_value;
    logic [NUM_DIGITS-1:0]           r_dp;
    logic [NUM_DIGITS-1:0]           r_blink;
    logic [NUM_DIGITS-1:0][6:0]      r_shadow;

    logic [NUM_DIGITS-1:0][6:0]      r_disp_seg;
    logic [NUM_DIGITS-1:0]           r_disp_dp_n;
    logic [NUM_DIGITS-1:0]           r_disp_blink;

    logic [NUM_DIGITS-1:0][6:0]      r_seg_out;
    logic [NUM_DIGITS-1:0]           r_dp_out;

    logic [CNT_W-1:0]                r_blink_cnt;
    logic                            r_phase;

    logic [3:0]                      w_nibble;
    logic [6:0]                      w_seg_enc;

    assign w_nibble   = r_value[r_idx];
    assign load_ready = (r_state == IDLE);

    seg7_hex_encode u_encode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_enc)
    );

    // Capture, per-digit decode into the shadow bank, and atomic commit to the display bank.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the shadow and display banks are flops cleared on reset, so they must not be
        // mapped to RAM; this guarantees a load cut short by reset never reaches the pins.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_lz         <= 1'b0;
            r_value      <= '0;
            r_dp         <= '0;
            r_blink      <= '0;
            r_shadow     <= {NUM_DIGITS{SEG_BLANK}};
            r_disp_seg   <= {NUM_DIGITS{SEG_BLANK}};
            r_disp_dp_n  <= '1;
            r_disp_blink <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_value <= load_value;
                        r_dp    <= load_dp;
                        r_blink <= load_blink;
                        r_lz    <= load_blank_lz;
                        r_idx   <= IDX_W'(NUM_DIGITS - 1);
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (r_lz && (w_nibble == 4'h0) && (r_idx != '0)) begin
                        r_shadow[r_idx] <= SEG_BLANK;
                    end else begin
                        r_shadow[r_idx] <= ~w_seg_enc;
                        r_lz            <= 1'b0;
                    end
                    if (r_idx == '0) begin
                        r_state <= COMMIT;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                COMMIT: begin
                    r_disp_seg   <= r_shadow;
                    r_disp_dp_n  <= ~r_dp;
                    r_disp_blink <= r_blink;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Free-running blink prescaler; loads and commits never touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_out <= {NUM_DIGITS{SEG_BLANK}};
            r_dp_out  <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_seg_out[i] <= (r_phase && r_disp_blink[i]) ? SEG_BLANK : r_disp_seg[i];
                r_dp_out[i]  <= (r_phase && r_disp_blink[i]) ? 1'b1 : r_disp_dp_n[i];
            end
        end
    end

    assign seg_out = r_seg_out;
    assign dp_out  = r_dp_out;

endmodule
